// File: rtl/reg_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : reg_wb_queue
// Description : Write-back FIFO merging load-return and ALU-result writes into
//               one register-file write port, with two forwarding lookups.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_we,
    input  logic [4:0]              mem_waddr,
    input  logic [31:0]             mem_wdata,
    input  logic                    ex_we,
    input  logic [4:0]              ex_waddr,
    input  logic [31:0]             ex_wdata,
    output logic                    wb_we,
    output logic [4:0]              wb_waddr,
    output logic [31:0]             wb_wdata,
    input  logic [4:0]              fwd_raddr1,
    input  logic [4:0]              fwd_raddr2,
    output logic                    fwd_hit1,
    output logic                    fwd_hit2,
    output logic [31:0]             fwd_data1,
    output logic [31:0]             fwd_data2,
    output logic                    stall_req,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;

    logic [4:0]      r_q_addr [DEPTH];
    logic [31:0]     r_q_data [DEPTH];
    logic [c_aw-1:0] r_head;
    logic [c_aw-1:0] r_tail;
    logic [c_cw-1:0] r_count;
    logic            r_wb_we;
    logic [4:0]      r_wb_waddr;
    logic [31:0]     r_wb_wdata;
    logic            r_overflow;

    logic            w_pop;
    logic [c_cw-1:0] w_free;
    logic            w_mem_req;
    logic            w_ex_req;
    logic            w_mem_acc;
    logic            w_ex_acc;
    logic            w_drop;
    logic [c_cw-1:0] w_count_next;
    logic [c_aw-1:0] w_ex_slot;

    // The head leaving this edge frees its slot for this edge's pushes.
    assign w_pop        = (r_count != '0);
    assign w_free       = c_cw'(DEPTH) - r_count + c_cw'(w_pop);
    assign w_mem_req    = mem_we && (mem_waddr != 5'd0);
    assign w_ex_req     = ex_we && (ex_waddr != 5'd0);
    assign w_mem_acc    = w_mem_req && (w_free >= c_cw'(1));
    assign w_ex_acc     = w_ex_req && (w_free >= (w_mem_acc ? c_cw'(2) : c_cw'(1)));
    assign w_drop       = (w_mem_req && !w_mem_acc) || (w_ex_req && !w_ex_acc);
    assign w_count_next = r_count - c_cw'(w_pop) + c_cw'(w_mem_acc) + c_cw'(w_ex_acc);
    assign w_ex_slot    = r_tail + c_aw'(w_mem_acc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_wb_we    <= 1'b0;
            r_wb_waddr <= '0;
            r_wb_wdata <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop) begin
                r_wb_we    <= 1'b1;
                r_wb_waddr <= r_q_addr[r_head];
                r_wb_wdata <= r_q_data[r_head];
                r_head     <= r_head + c_aw'(1);
            end else begin
                r_wb_we    <= 1'b0;
            end
            r_tail  <= r_tail + c_aw'(w_mem_acc) + c_aw'(w_ex_acc);
            r_count <= w_count_next;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: occupancy alone decides which slots are valid.
    always_ff @(posedge clk) begin
        if (w_mem_acc) begin
            r_q_addr[r_tail] <= mem_waddr;
            r_q_data[r_tail] <= mem_wdata;
        end
        if (w_ex_acc) begin
            r_q_addr[w_ex_slot] <= ex_waddr;
            r_q_data[w_ex_slot] <= ex_wdata;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_fwd
        logic [4:0]  raddr;
        logic        hit;
        logic [31:0] data;

        assign raddr = (p == 0) ? fwd_raddr1 : fwd_raddr2;

        // Later assignments override earlier ones: youngest entry, then mem, then ex.
        always_comb begin
            hit  = 1'b0;
            data = '0;
            if (raddr != 5'd0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if ((c_cw'(i) < r_count) && (r_q_addr[r_head + c_aw'(i)] == raddr)) begin
                        hit  = 1'b1;
                        data = r_q_data[r_head + c_aw'(i)];
                    end
                end
                if (mem_we && (mem_waddr == raddr)) begin
                    hit  = 1'b1;
                    data = mem_wdata;
                end
                if (ex_we && (ex_waddr == raddr)) begin
                    hit  = 1'b1;
                    data = ex_wdata;
                end
            end
        end
    end

    assign fwd_hit1  = g_fwd[0].hit;
    assign fwd_data1 = g_fwd[0].data;
    assign fwd_hit2  = g_fwd[1].hit;
    assign fwd_data2 = g_fwd[1].data;

    assign stall_req = (c_cw'(DEPTH) - r_count) < c_cw'(2);
    assign count     = r_count;
    assign wb_we     = r_wb_we;
    assign wb_waddr  = r_wb_waddr;
    assign wb_wdata  = r_wb_wdata;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_reg_wb_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_wb_queue
// Description : Scoreboard bench for reg_wb_queue (DEPTH = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_wb_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_we, ex_we;
    logic [4:0]  mem_waddr, ex_waddr;
    logic [31:0] mem_wdata, ex_wdata;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic [4:0]  fwd_raddr1, fwd_raddr2;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;
    logic        stall_req;
    logic [2:0]  count;
    logic        overflow;

    reg_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .fwd_raddr1(fwd_raddr1), .fwd_raddr2(fwd_raddr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .stall_req(stall_req), .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [36:0] sb[$];
    int          mcount = 0;
    logic        movf   = 1'b0;
    logic [36:0] last_wb = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [32:0] fwd_model(input logic [4:0] ra,
            input logic mw, input logic [4:0] ma, input logic [31:0] md,
            input logic ew, input logic [4:0] ea, input logic [31:0] ed);
        if (ra == 5'd0) return '0;
        if (ew && ea == ra) return {1'b1, ed};
        if (mw && ma == ra) return {1'b1, md};
        for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i][36:32] == ra) return {1'b1, sb[i][31:0]};
        return '0;
    endfunction

    task automatic step(input logic mw, input logic [4:0] ma, input logic [31:0] md,
                        input logic ew, input logic [4:0] ea, input logic [31:0] ed);
        logic        pop, macc, eacc;
        int          free;
        logic [32:0] f;
        logic [36:0] exp_wb;
        @(negedge clk);
        mem_we = mw; mem_waddr = ma; mem_wdata = md;
        ex_we  = ew; ex_waddr  = ea; ex_wdata  = ed;
        #1;
        chk("stall", stall_req, (DEPTH - mcount) < 2);
        f = fwd_model(fwd_raddr1, mw, ma, md, ew, ea, ed);
        chk("fwd_hit1", fwd_hit1, f[32]);
        chk("fwd_data1", fwd_data1, f[31:0]);
        f = fwd_model(fwd_raddr2, mw, ma, md, ew, ea, ed);
        chk("fwd_hit2", fwd_hit2, f[32]);
        chk("fwd_data2", fwd_data2, f[31:0]);
        pop  = (mcount > 0);
        free = DEPTH - mcount + int'(pop);
        macc = mw && (ma != 0) && (free >= 1);
        eacc = ew && (ea != 0) && (free >= 1 + int'(macc));
        if ((mw && ma != 0 && !macc) || (ew && ea != 0 && !eacc)) movf = 1'b1;
        exp_wb = last_wb;
        if (pop) exp_wb = sb.pop_front();
        if (macc) sb.push_back({ma, md});
        if (eacc) sb.push_back({ea, ed});
        mcount = mcount - int'(pop) + int'(macc) + int'(eacc);
        @(posedge clk);
        #1;
        chk("wb_we", wb_we, pop);
        chk("wb_addr_data", {wb_waddr, wb_wdata}, exp_wb);
        last_wb = exp_wb;
        chk("count", count, mcount);
        chk("overflow", overflow, movf);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        mem_we = 0; mem_waddr = 0; mem_wdata = 0;
        ex_we = 0; ex_waddr = 0; ex_wdata = 0;
        fwd_raddr1 = 0; fwd_raddr2 = 0;
        #3;
        chk("rst_count", count, 0);
        chk("rst_wb_we", wb_we, 0);
        chk("rst_wb", {wb_waddr, wb_wdata}, 0);
        chk("rst_ovf", overflow, 0);
        @(negedge clk);
        rst = 1'b0;

        // single ALU write
        step(0, 0, 0, 1, 5'd5, 32'h1234);
        idle(2);
        // dual write, mem first
        step(1, 5'd3, 32'hAAAA, 1, 5'd4, 32'hBBBB);
        idle(3);
        // forwarding: queue holds r7=0x11, r7=0x22
        step(1, 5'd7, 32'h11, 1, 5'd7, 32'h22);
        fwd_raddr1 = 5'd7; fwd_raddr2 = 5'd9;
        step(0, 0, 0, 1, 5'd9, 32'h99);
        fwd_raddr2 = 5'd0;
        step(0, 0, 0, 1, 5'd0, 32'h55);
        idle(2);
        // zero register
        step(0, 0, 0, 1, 5'd0, 32'hDEAD);
        fwd_raddr1 = 5'd12; fwd_raddr2 = 5'd13;
        // fill to overflow
        for (int k = 0; k < 4; k++)
            step(1, 5'(10 + 2 * k), 32'h100 + k, 1, 5'(11 + 2 * k), 32'h200 + k);
        idle(5);
        // reset mid-drain
        step(1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
        step(1, 5'd3, 32'h3, 1, 5'd4, 32'h4);
        @(negedge clk);
        mem_we = 0; ex_we = 0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_count", count, 0);
        chk("mid_rst_wb_we", wb_we, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_stall", stall_req, 0);
        sb.delete(); mcount = 0; movf = 1'b0; last_wb = '0;
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        // random mix
        for (int k = 0; k < 60; k++) begin
            fwd_raddr1 = 5'($urandom_range(0, 7));
            fwd_raddr2 = 5'($urandom_range(0, 7));
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
        end
        idle(5);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/reg_wb_queue.md
REG_WB_QUEUE -- requirements
Module: reg_wb_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, >= 4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port mem_we  input  1  load-return write request (older source).
REQ-005 SHALL have port mem_waddr  input  5  load-return destination register.
REQ-006 SHALL have port mem_wdata  input  32  load-return data.
REQ-007 SHALL have port ex_we  input  1  ALU-result write request (younger source).
REQ-008 SHALL have port ex_waddr  input  5  ALU-result destination register.
REQ-009 SHALL have port ex_wdata  input  32  ALU-result data.
REQ-010 SHALL have port wb_we  output  1  register file write enable, registered.
REQ-011 SHALL have port wb_waddr  output  5  register file write address, registered.
REQ-012 SHALL have port wb_wdata  output  32  register file write data, registered.
REQ-013 SHALL have ports fwd_raddr1 / fwd_raddr2  input  5 each  forwarding lookup addresses.
REQ-014 SHALL have ports fwd_hit1 / fwd_hit2  output  1 each  lookup matched a pending write.
REQ-015 SHALL have ports fwd_data1 / fwd_data2  output  32 each  forwarded data, 0 when no hit.
REQ-016 SHALL have port stall_req  output  1  upstream must not present new requests.
REQ-017 SHALL have port count  output  log2(DEPTH)+1  current queue occupancy.
REQ-018 SHALL have port overflow  output  1  sticky: a request was dropped for lack of space.

Function
REQ-019 SHALL be a FIFO of (waddr, wdata) entries draining into the single register file write port.
REQ-020 SHALL discard any request whose waddr is 0 at enqueue; it occupies no entry and never sets overflow.
REQ-021 SHALL, when both sources request in one cycle, enqueue the mem entry before the ex entry (program order).
REQ-022 SHALL pop the head at every rising edge where count > 0 before that edge, loading wb_we=1, wb_waddr/wb_wdata from the head.
REQ-023 SHALL drive wb_we=0 (wb_waddr/wb_wdata holding their previous values) after any edge where count was 0.
REQ-024 SHALL exhibit fixed latency: a request presented in cycle t appears on wb_* after edge t+1 if it is the queue head after edge t.
REQ-025 SHALL support simultaneous pop and up to two pushes per edge; count_next = count - pop + pushes accepted.
REQ-026 SHALL compute free slots as DEPTH - count + pop for acceptance; requests beyond free slots SHALL be dropped (ex dropped first) and set overflow.
REQ-027 SHALL assert stall_req combinationally when DEPTH - count < 2.
REQ-028 SHALL wrap head/tail pointers modulo DEPTH with no bubble.
REQ-029 SHALL resolve forwarding combinationally with priority: ex input (ex_we, nonzero matching addr) > mem input > youngest matching queue entry > no hit.
REQ-030 SHALL return fwd_hit=0, fwd_data=0 for lookup address 0.
REQ-031 SHALL NOT include the entry currently on wb_* in forwarding (the register file write-port bypass covers it).
REQ-032 SHALL keep both lookup ports independent and fully parallel.

Reset
REQ-033 SHALL, while rst=1, immediately force count=0, pointers=0, wb_we=0, wb_waddr=0, wb_wdata=0, overflow=0, irrespective of clk.
REQ-034 SHALL discard all queued entries on reset mid-operation; no write issues on the first edge after release.
REQ-035 SHALL clear overflow only by reset.

Verification
REQ-036 Single: ex_we=1, ex_waddr=5, ex_wdata=0x1234 for one cycle -> count=1 after edge 1; wb_we=1, wb_waddr=5, wb_wdata=0x1234 after edge 2; wb_we=0 after edge 3.
REQ-037 Dual: mem (r3, 0xAAAA) and ex (r4, 0xBBBB) same cycle -> wb writes r3 then r4 on consecutive edges; count 2,1,0.
REQ-038 Forward: queue holds r7=0x11 then r7=0x22, ex input r9 -> fwd_raddr1=7 gives hit, 0x22; fwd_raddr2=9 gives hit, ex_wdata; raddr 0 gives hit=0, data=0.
REQ-039 Full: push two per cycle for 4 cycles, DEPTH=4 -> stall_req high at count>=3, ex request dropped when free slots <2, overflow=1 and sticky.
REQ-040 Zero reg: ex_we=1, ex_waddr=0 -> count unchanged, wb_we stays 0, overflow stays 0.
REQ-041 Reset mid-drain: count=3, assert rst between edges -> count=0, wb_we=0 immediately; after release no write occurs without new requests.
